// File: rtl/transmitter_datapath.sv
// UART transmitter serial datapath: frames data_in as start+data+[parity]+stop
// and shifts it out LSB-first on tx, one bit per qualified count_pulse.
module transmitter_datapath #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 load_pulse,
  input  logic                 reset_pulse,
  input  logic                 shift,
  input  logic                 count_pulse,
  output logic                 tx,
  output logic                 count,
  output logic                 busy
);

  localparam int FRAME = 1 + DATA_BITS + PARITY_EN + STOP_BITS;
  localparam int CNT_W = $clog2(FRAME + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME);

  logic [FRAME-1:0] r_shreg;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_tx;
  logic             r_count;
  logic             r_busy;

  logic [FRAME-1:0] w_frame;
  logic             w_parity;
  logic             w_advance;

  assign w_parity  = (PARITY_ODD != 0) ? ~^data_in : ^data_in;
  assign w_advance = shift & count_pulse & r_busy;

  // Stop bits fill the top of the frame; with parity off the slot above the
  // data simply stays a stop bit.
  always_comb begin
    w_frame                = '1;
    w_frame[0]             = 1'b0;
    w_frame[DATA_BITS:1]   = data_in;
    if (PARITY_EN != 0) begin
      w_frame[DATA_BITS+1] = w_parity;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    r_count <= 1'b0;
    if (reset || reset_pulse) begin
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_bit_cnt <= '0;
      r_shreg   <= '1;
    end else if (load_pulse) begin
      r_shreg   <= w_frame;
      r_bit_cnt <= '0;
      r_busy    <= 1'b1;
    end else if (w_advance) begin
      if (r_bit_cnt == LAST_CNT) begin
        // Last stop bit has been held a full baud period.
        r_tx      <= 1'b1;
        r_busy    <= 1'b0;
        r_bit_cnt <= '0;
        r_count   <= 1'b1;
      end else begin
        r_tx      <= r_shreg[0];
        r_shreg   <= {1'b1, r_shreg[FRAME-1:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  assign tx    = r_tx;
  assign count = r_count;
  assign busy  = r_busy;

endmodule

// File: tb/tb_transmitter_datapath.sv
// Directed bench for transmitter_datapath: four configurations (8N1, 8E1,
// 8O1, 8N2) share one stimulus bus; each test checks the instance it targets.
module tb_transmitter_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       load_pulse;
  logic       reset_pulse;
  logic       shift;
  logic       count_pulse;

  logic       w_tx    [4];
  logic       w_count [4];
  logic       w_busy  [4];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  transmitter_datapath #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .data_in(data_in), .load_pulse(load_pulse),
    .reset_pulse(reset_pulse), .shift(shift), .count_pulse(count_pulse),
    .tx(w_tx[0]), .count(w_count[0]), .busy(w_busy[0]));

  transmitter_datapath #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset(reset), .data_in(data_in), .load_pulse(load_pulse),
    .reset_pulse(reset_pulse), .shift(shift), .count_pulse(count_pulse),
    .tx(w_tx[1]), .count(w_count[1]), .busy(w_busy[1]));

  transmitter_datapath #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .reset(reset), .data_in(data_in), .load_pulse(load_pulse),
    .reset_pulse(reset_pulse), .shift(shift), .count_pulse(count_pulse),
    .tx(w_tx[2]), .count(w_count[2]), .busy(w_busy[2]));

  transmitter_datapath #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .reset(reset), .data_in(data_in), .load_pulse(load_pulse),
    .reset_pulse(reset_pulse), .shift(shift), .count_pulse(count_pulse),
    .tx(w_tx[3]), .count(w_count[3]), .busy(w_busy[3]));

  // One qualifying strobe, then one idle cycle; outputs are sampled on the
  // negedge right after the posedge that consumed the strobe.
  task automatic pulse();
    @(negedge clk);
    count_pulse = 1'b1;
    @(negedge clk);
    count_pulse = 1'b0;
  endtask

  task automatic load(input logic [7:0] d, input int inst, input string tag);
    @(negedge clk);
    data_in    = d;
    load_pulse = 1'b1;
    @(negedge clk);
    load_pulse = 1'b0;
    n_vec++;
    if (w_busy[inst] !== 1'b1 || w_tx[inst] !== 1'b1 || w_count[inst] !== 1'b0) begin
      n_err++;
      $display("FAIL %s load: busy=%b tx=%b count=%b, want busy=1 tx=1 count=0",
               tag, w_busy[inst], w_tx[inst], w_count[inst]);
    end
  endtask

  // Shift nbits frame bits (bits[0] first); if do_end, add the completion pulse.
  task automatic run_frame(input int inst, input logic [11:0] bits, input int nbits,
                           input bit do_end, input string tag);
    for (int k = 0; k < nbits; k++) begin
      pulse();
      n_vec++;
      if (w_tx[inst] !== bits[k] || w_count[inst] !== 1'b0 || w_busy[inst] !== 1'b1) begin
        n_err++;
        $display("FAIL %s bit%0d: tx=%b count=%b busy=%b, want tx=%b count=0 busy=1",
                 tag, k, w_tx[inst], w_count[inst], w_busy[inst], bits[k]);
      end
    end
    if (do_end) begin
      pulse();
      n_vec++;
      if (w_count[inst] !== 1'b1 || w_busy[inst] !== 1'b0 || w_tx[inst] !== 1'b1) begin
        n_err++;
        $display("FAIL %s end: count=%b busy=%b tx=%b, want count=1 busy=0 tx=1",
                 tag, w_count[inst], w_busy[inst], w_tx[inst]);
      end
      @(negedge clk);
      n_vec++;
      if (w_count[inst] !== 1'b0) begin
        n_err++;
        $display("FAIL %s count_clear: count=%b, want 0", tag, w_count[inst]);
      end
    end
  endtask

  task automatic idle_pulses(input int inst, input int n, input logic want_busy, input string tag);
    for (int k = 0; k < n; k++) begin
      pulse();
      n_vec++;
      if (w_tx[inst] !== 1'b1 || w_count[inst] !== 1'b0 || w_busy[inst] !== want_busy) begin
        n_err++;
        $display("FAIL %s pulse%0d: tx=%b count=%b busy=%b, want tx=1 count=0 busy=%b",
                 tag, k, w_tx[inst], w_count[inst], w_busy[inst], want_busy);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; data_in = 8'h00; load_pulse = 1'b0; reset_pulse = 1'b0;
    shift = 1'b1; count_pulse = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (w_tx[i] !== 1'b1 || w_count[i] !== 1'b0 || w_busy[i] !== 1'b0) begin
        n_err++;
        $display("FAIL reset inst%0d: tx=%b count=%b busy=%b, want 1 0 0",
                 i, w_tx[i], w_count[i], w_busy[i]);
      end
    end
  endtask

  task automatic test_8n1();
    load(8'hA5, 0, "8n1_a5");
    run_frame(0, 12'h34A, 10, 1'b1, "8n1_a5");
  endtask

  task automatic test_parity();
    load(8'h07, 1, "8e1_07");
    run_frame(1, 12'h60E, 11, 1'b1, "8e1_07");
    load(8'h07, 2, "8o1_07");
    run_frame(2, 12'h40E, 11, 1'b1, "8o1_07");
  endtask

  task automatic test_abort();
    load(8'hA5, 0, "abort");
    run_frame(0, 12'h34A, 4, 1'b0, "abort");
    @(negedge clk);
    reset_pulse = 1'b1;
    @(negedge clk);
    reset_pulse = 1'b0;
    n_vec++;
    if (w_tx[0] !== 1'b1 || w_busy[0] !== 1'b0 || w_count[0] !== 1'b0) begin
      n_err++;
      $display("FAIL abort: tx=%b busy=%b count=%b, want 1 0 0", w_tx[0], w_busy[0], w_count[0]);
    end
    idle_pulses(0, 12, 1'b0, "abort_after");
  endtask

  task automatic test_held_load();
    logic [7:0] seq [5];
    seq = '{8'h11, 8'h22, 8'h2D, 8'h33, 8'h3C};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k > 0) begin
        n_vec++;
        if (w_tx[0] !== 1'b1 || w_busy[0] !== 1'b1) begin
          n_err++;
          $display("FAIL held_load cyc%0d: tx=%b busy=%b, want tx=1 busy=1", k, w_tx[0], w_busy[0]);
        end
      end
      data_in     = seq[k];
      load_pulse  = 1'b1;
      count_pulse = (k % 2 == 0);
    end
    @(negedge clk);
    load_pulse  = 1'b0;
    count_pulse = 1'b0;
    n_vec++;
    if (w_tx[0] !== 1'b1 || w_busy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL held_load drop: tx=%b busy=%b, want tx=1 busy=1", w_tx[0], w_busy[0]);
    end
    run_frame(0, 12'h278, 10, 1'b1, "held_load_3c");
  endtask

  task automatic test_no_shift();
    idle_pulses(0, 3, 1'b0, "idle");
    load(8'hA5, 0, "no_shift");
    shift = 1'b0;
    idle_pulses(0, 12, 1'b1, "no_shift");
    shift = 1'b1;
    run_frame(0, 12'h34A, 10, 1'b1, "no_shift_resume");
  endtask

  task automatic test_stop2();
    load(8'hFF, 3, "8n2_ff");
    run_frame(3, 12'h7FE, 11, 1'b1, "8n2_ff");
    load(8'h00, 3, "8n2_00");
    run_frame(3, 12'h600, 11, 1'b1, "8n2_00");
  endtask

  task automatic test_back_to_back();
    load(8'hA5, 0, "b2b");
    run_frame(0, 12'h34A, 10, 1'b0, "b2b");
    @(negedge clk);
    count_pulse = 1'b1;
    load_pulse  = 1'b1;
    data_in     = 8'h3C;
    @(negedge clk);
    count_pulse = 1'b0;
    load_pulse  = 1'b0;
    n_vec++;
    if (w_count[0] !== 1'b0 || w_busy[0] !== 1'b1 || w_tx[0] !== 1'b1) begin
      n_err++;
      $display("FAIL b2b collide: count=%b busy=%b tx=%b, want 0 1 1", w_count[0], w_busy[0], w_tx[0]);
    end
    run_frame(0, 12'h278, 10, 1'b1, "b2b_3c");
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_abort();
    test_held_load();
    test_no_shift();
    test_stop2();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
